// File: rtl/order_gen_pkg.sv
// order_gen shared types and message layout.
// Frame: header, price BE, qty BE, xor.
package order_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    COOL = 2'd2
  } state_e;

  localparam logic [7:0] HDR_BYTE = 8'hA5;
  localparam int         MSG_LEN  = 10;

  // Byte idx of the order frame for a latched price/qty pair.
  function automatic logic [7:0] msg_byte(
    input logic [3:0]  idx,
    input logic [31:0] p,
    input logic [31:0] q
  );
    logic [7:0] ck;
    ck = p[31:24] ^ p[23:16] ^ p[15:8] ^ p[7:0]
       ^ q[31:24] ^ q[23:16] ^ q[15:8] ^ q[7:0];
    case (idx)
      4'd0:    msg_byte = HDR_BYTE;
      4'd1:    msg_byte = p[31:24];
      4'd2:    msg_byte = p[23:16];
      4'd3:    msg_byte = p[15:8];
      4'd4:    msg_byte = p[7:0];
      4'd5:    msg_byte = q[31:24];
      4'd6:    msg_byte = q[23:16];
      4'd7:    msg_byte = q[15:8];
      4'd8:    msg_byte = q[7:0];
      4'd9:    msg_byte = ck;
      default: msg_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/order_gen_sat_cnt16.sv
// sat_cnt16: 16-bit event counter.
// Sticks at all-ones instead of wrapping.
module sat_cnt16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  output logic [15:0] cnt_o
);

  logic [15:0] cnt_q, cnt_d;

  // Increment on enable unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'h0000;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/order_gen.sv
// order_gen: turns qualifying price/qty ticks
// into 10-byte order frames with cooldown.
module order_gen
  import order_gen_pkg::*;
#(
  parameter logic [31:0] PRICE_LIMIT = 32'd1000,
  parameter logic [31:0] MAX_QTY     = 32'd500,
  parameter int          COOLDOWN    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        packet_detected,
  input  logic [31:0] price,
  input  logic [31:0] quantity,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic [15:0] order_count,
  output logic [15:0] drop_count
);

  state_e      state_q, state_d;
  logic [31:0] price_q, price_d;
  logic [31:0] qty_q, qty_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] cool_q, cool_d;
  logic        qualify;
  logic        sent;
  logic        drop;
  logic [31:0] qty_clip;

  assign qualify = packet_detected
                && (price <= PRICE_LIMIT)
                && (quantity != 32'd0);

  assign qty_clip = (quantity > MAX_QTY) ? MAX_QTY : quantity;

  // Next-state: accept in IDLE, stream in SEND, wait in COOL.
  always_comb begin
    state_d = state_q;
    price_d = price_q;
    qty_d   = qty_q;
    idx_d   = idx_q;
    cool_d  = cool_q;
    sent    = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (qualify) begin
          price_d = price;
          qty_d   = qty_clip;
          idx_d   = 4'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        drop = qualify;
        if (tx_ready) begin
          if (idx_q == 4'(MSG_LEN - 1)) begin
            sent  = 1'b1;
            idx_d = 4'd0;
            if (COOLDOWN == 0) begin
              state_d = IDLE;
            end else begin
              state_d = COOL;
              cool_d  = 16'(COOLDOWN - 1);
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      COOL: begin
        drop = qualify;
        if (cool_q == 16'd0) begin
          state_d = IDLE;
        end else begin
          cool_d = cool_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched order registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      price_q <= 32'd0;
      qty_q   <= 32'd0;
      idx_q   <= 4'd0;
      cool_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      price_q <= price_d;
      qty_q   <= qty_d;
      idx_q   <= idx_d;
      cool_q  <= cool_d;
    end
  end

  assign tx_valid = (state_q == SEND);
  assign tx_data  = tx_valid
                  ? msg_byte(idx_q, price_q, qty_q)
                  : 8'h00;

  sat_cnt16 u_order_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (sent),
    .cnt_o (order_count)
  );

  sat_cnt16 u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (drop),
    .cnt_o (drop_count)
  );

endmodule

// File: tb/tb_order_gen.sv
// Self-checking bench for order_gen.
// Directed scenarios plus a queue-based random model.
module tb_order_gen;

  localparam logic [31:0] PL = 32'd1000;
  localparam logic [31:0] MQ = 32'd500;
  localparam int          CD = 16;

  logic        clk;
  logic        rst_n;
  logic        packet_detected;
  logic [31:0] price;
  logic [31:0] quantity;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic [15:0] order_count;
  logic [15:0] drop_count;

  int checks;
  int errors;

  logic [7:0] exp_msg [10];
  logic [7:0] golden  [10] = '{8'hA5, 8'h00, 8'h00, 8'h03, 8'h84,
                               8'h00, 8'h00, 8'h00, 8'hC8, 8'h4F};

  order_gen #(
    .PRICE_LIMIT (PL),
    .MAX_QTY     (MQ),
    .COOLDOWN    (CD)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .packet_detected (packet_detected),
    .price           (price),
    .quantity        (quantity),
    .tx_ready        (tx_ready),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .order_count     (order_count),
    .drop_count      (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected frame from plain arithmetic on the order fields.
  task automatic make_msg(input logic [31:0] p, input logic [31:0] q);
    logic [31:0] qc;
    logic [7:0]  ck;
    qc = (q > MQ) ? MQ : q;
    exp_msg[0] = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      exp_msg[1 + i] = 8'(p >> (24 - 8 * i));
      exp_msg[5 + i] = 8'(qc >> (24 - 8 * i));
    end
    ck = 8'h00;
    for (int i = 1; i <= 8; i++) ck = ck ^ exp_msg[i];
    exp_msg[9] = ck;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    packet_detected = 1'b0;
    price = 32'd0;
    quantity = 32'd0;
    tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One-cycle packet pulse; returns on the following negedge.
  task automatic pulse(input logic [31:0] p, input logic [31:0] q);
    packet_detected = 1'b1;
    price = p;
    quantity = q;
    @(negedge clk);
    packet_detected = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    packet_detected = 1'b0;
    price = 32'd0;
    quantity = 32'd0;
    tx_ready = 1'b1;
    #2;
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00 ||
        order_count !== 16'd0 || drop_count !== 16'd0) begin
      errors++;
      $display("FAIL reset: got v=%b d=%h oc=%0d dc=%0d, want 0 00 0 0",
               tx_valid, tx_data, order_count, drop_count);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_release: got v=%b d=%h, want 0 00",
               tx_valid, tx_data);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    pulse(32'd900, 32'd200);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== golden[k]) begin
        errors++;
        $display("FAIL basic_byte%0d: got v=%b d=%h, want v=1 d=%h",
                 k, tx_valid, tx_data, golden[k]);
      end
      @(negedge clk);
    end
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00 ||
        order_count !== 16'd1 || drop_count !== 16'd0) begin
      errors++;
      $display("FAIL basic_end: got v=%b d=%h oc=%0d dc=%0d, want 0 00 1 0",
               tx_valid, tx_data, order_count, drop_count);
    end
  endtask

  task automatic test_limit();
    logic seen;
    apply_reset();
    pulse(32'd1001, 32'd10);
    seen = 1'b0;
    repeat (12) begin
      if (tx_valid !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    pulse(32'd5, 32'd0);
    repeat (12) begin
      if (tx_valid !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen || order_count !== 16'd0 || drop_count !== 16'd0) begin
      errors++;
      $display("FAIL limit_ignore: got seen=%b oc=%0d dc=%0d, want 0 0 0",
               seen, order_count, drop_count);
    end
    make_msg(32'd1000, 32'd10);
    pulse(32'd1000, 32'd10);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp_msg[k]) begin
        errors++;
        $display("FAIL limit_byte%0d: got v=%b d=%h, want v=1 d=%h",
                 k, tx_valid, tx_data, exp_msg[k]);
      end
      @(negedge clk);
    end
    checks++;
    if (order_count !== 16'd1) begin
      errors++;
      $display("FAIL limit_count: got %0d, want 1", order_count);
    end
  endtask

  task automatic test_clip();
    logic [7:0] got [10];
    apply_reset();
    make_msg(32'd700, 32'd800);
    pulse(32'd700, 32'd800);
    for (int k = 0; k < 10; k++) begin
      got[k] = tx_data;
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp_msg[k]) begin
        errors++;
        $display("FAIL clip_byte%0d: got v=%b d=%h, want v=1 d=%h",
                 k, tx_valid, tx_data, exp_msg[k]);
      end
      @(negedge clk);
    end
    checks++;
    if ({got[5], got[6], got[7], got[8]} !== 32'h0000_01F4) begin
      errors++;
      $display("FAIL clip_qty: got %h%h%h%h, want 000001f4",
               got[5], got[6], got[7], got[8]);
    end
  endtask

  task automatic test_backpressure();
    logic held;
    apply_reset();
    pulse(32'd900, 32'd200);
    held = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin
        tx_ready = 1'b0;
        repeat (5) begin
          if (tx_valid !== 1'b1 || tx_data !== 8'h03) held = 1'b0;
          @(negedge clk);
        end
        tx_ready = 1'b1;
        checks++;
        if (!held) begin
          errors++;
          $display("FAIL bp_hold: got v=%b d=%h, want held 1 03",
                   tx_valid, tx_data);
        end
      end
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== golden[k]) begin
        errors++;
        $display("FAIL bp_byte%0d: got v=%b d=%h, want v=1 d=%h",
                 k, tx_valid, tx_data, golden[k]);
      end
      @(negedge clk);
    end
    checks++;
    if (tx_valid !== 1'b0 || order_count !== 16'd1) begin
      errors++;
      $display("FAIL bp_end: got v=%b oc=%0d, want 0 1",
               tx_valid, order_count);
    end
  endtask

  task automatic test_drop();
    logic quiet;
    apply_reset();
    pulse(32'd900, 32'd200);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== golden[k]) begin
        errors++;
        $display("FAIL drop_byte%0d: got v=%b d=%h, want v=1 d=%h",
                 k, tx_valid, tx_data, golden[k]);
      end
      packet_detected = (k == 4);
      price = 32'd50;
      quantity = 32'd7;
      @(negedge clk);
    end
    packet_detected = 1'b0;
    quiet = 1'b1;
    repeat (CD - 1) begin
      if (tx_valid !== 1'b0) quiet = 1'b0;
      @(negedge clk);
    end
    pulse(32'd60, 32'd9);
    checks++;
    if (!quiet || tx_valid !== 1'b0 || drop_count !== 16'd2 ||
        order_count !== 16'd1) begin
      errors++;
      $display("FAIL drop_cool: got quiet=%b v=%b dc=%0d oc=%0d, want 1 0 2 1",
               quiet, tx_valid, drop_count, order_count);
    end
    make_msg(32'd70, 32'd11);
    pulse(32'd70, 32'd11);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp_msg[k]) begin
        errors++;
        $display("FAIL drop_idle_byte%0d: got v=%b d=%h, want v=1 d=%h",
                 k, tx_valid, tx_data, exp_msg[k]);
      end
      @(negedge clk);
    end
    checks++;
    if (order_count !== 16'd2 || drop_count !== 16'd2) begin
      errors++;
      $display("FAIL drop_end: got oc=%0d dc=%0d, want 2 2",
               order_count, drop_count);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    pulse(32'd900, 32'd200);
    repeat (10) @(negedge clk);
    repeat (CD + 1) @(negedge clk);
    pulse(32'd900, 32'd200);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00 ||
        order_count !== 16'd0 || drop_count !== 16'd0) begin
      errors++;
      $display("FAIL rst_mid: got v=%b d=%h oc=%0d dc=%0d, want 0 00 0 0",
               tx_valid, tx_data, order_count, drop_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    make_msg(32'd333, 32'd44);
    pulse(32'd333, 32'd44);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp_msg[k]) begin
        errors++;
        $display("FAIL rst_new_byte%0d: got v=%b d=%h, want v=1 d=%h",
                 k, tx_valid, tx_data, exp_msg[k]);
      end
      @(negedge clk);
    end
    checks++;
    if (order_count !== 16'd1) begin
      errors++;
      $display("FAIL rst_new_count: got %0d, want 1", order_count);
    end
  endtask

  // Queue of pending bytes plus a cooldown budget.
  task automatic test_random();
    logic [7:0] q[$];
    int         cool;
    int         m_orders;
    int         m_drops;
    int         shown;
    logic       busy;
    logic       qual;
    logic       e_v;
    logic [7:0] e_d;
    apply_reset();
    cool = 0;
    m_orders = 0;
    m_drops = 0;
    shown = 0;
    for (int c = 0; c < 3000; c++) begin
      packet_detected = ($urandom_range(0, 3) == 0);
      price = ($urandom_range(0, 4) == 0) ? $urandom
                                          : $urandom_range(0, 1100);
      if ($urandom_range(0, 4) == 0) quantity = 32'd0;
      else if ($urandom_range(0, 1) == 1) quantity = $urandom_range(1, 1000);
      else quantity = $urandom;
      tx_ready = ($urandom_range(0, 3) != 0);
      #1;
      e_v = (q.size() > 0);
      e_d = e_v ? q[0] : 8'h00;
      checks++;
      if (tx_valid !== e_v || tx_data !== e_d ||
          order_count !== 16'(m_orders) || drop_count !== 16'(m_drops)) begin
        errors++;
        if (shown < 10) begin
          shown++;
          $display("FAIL rand_c%0d: got v=%b d=%h oc=%0d dc=%0d, want %b %h %0d %0d",
                   c, tx_valid, tx_data, order_count, drop_count,
                   e_v, e_d, m_orders, m_drops);
        end
      end
      busy = (q.size() > 0) || (cool > 0);
      qual = packet_detected && (price <= PL) && (quantity != 0);
      if (q.size() > 0) begin
        if (tx_ready) begin
          void'(q.pop_front());
          if (q.size() == 0) begin
            if (m_orders < 65535) m_orders++;
            cool = CD;
          end
        end
      end else if (cool > 0) begin
        cool--;
      end
      if (qual) begin
        if (busy) begin
          if (m_drops < 65535) m_drops++;
        end else begin
          make_msg(price, quantity);
          for (int i = 0; i < 10; i++) q.push_back(exp_msg[i]);
        end
      end
      @(negedge clk);
    end
    packet_detected = 1'b0;
    tx_ready = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    packet_detected = 1'b0;
    price = 32'd0;
    quantity = 32'd0;
    tx_ready = 1'b1;
    test_reset();
    test_basic();
    test_limit();
    test_clip();
    test_backpressure();
    test_drop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/order_gen.md
ORDER_GEN -- requirements
Module: order_gen

Interface
REQ-001 Parameter PRICE_LIMIT, default 32'd1000: highest price (inclusive) that triggers an order.
REQ-002 Parameter MAX_QTY, default 32'd500: order quantity ceiling; larger quantities are clipped.
REQ-003 Parameter COOLDOWN, default 16: idle cycles enforced after each sent order; 0 = none.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 packet_detected  input  1  one-cycle pulse from upstream feed handler: price/quantity valid this cycle.
REQ-007 price  input  32  extracted price, unsigned, sampled only when packet_detected=1.
REQ-008 quantity  input  32  extracted quantity, unsigned, sampled only when packet_detected=1.
REQ-009 tx_ready  input  1  downstream accepts tx_data this cycle.
REQ-010 tx_data  output  8  order message byte.
REQ-011 tx_valid  output  1  tx_data valid.
REQ-012 order_count  output  16  orders fully transmitted, saturating.
REQ-013 drop_count  output  16  qualifying packets discarded because busy, saturating.

Function
REQ-014 Qualifying packet: packet_detected=1, price <= PRICE_LIMIT, quantity != 0; all other packets ignored and uncounted.
REQ-015 FSM states IDLE, SEND, COOL; reset state IDLE.
REQ-016 IDLE + qualifying packet: latch price and min(quantity, MAX_QTY), clear byte index, go SEND; tx_valid=1 on the next cycle (latency 1).
REQ-017 Message is 10 bytes: 0xA5, price[31:24..7:0], qty[31:24..7:0], checksum = XOR of bytes 1-8.
REQ-018 Byte transfer only when tx_valid=1 and tx_ready=1; otherwise tx_data and tx_valid hold unchanged.
REQ-019 tx_valid stays 1 throughout SEND, including backpressure; 0 in IDLE and COOL.
REQ-020 Transfer of byte 9: order_count increments, go COOL (or IDLE directly if COOLDOWN=0), tx_valid=0 next cycle.
REQ-021 COOL lasts exactly COOLDOWN cycles, then IDLE; first trigger accepted on the first IDLE cycle.
REQ-022 Qualifying packet in SEND or COOL (including the final-byte-transfer cycle and the last COOL cycle): discarded, drop_count increments, latched message untouched.
REQ-023 Counters saturate at 16'hFFFF; no wrap.
REQ-024 tx_data value is don't-care when tx_valid=0 but driven to 8'h00.

Reset
REQ-025 rst_n low: state IDLE, tx_valid=0, tx_data=8'h00, order_count=0, drop_count=0, latched price/qty=0, byte index=0, cooldown counter=0, asynchronously.
REQ-026 Reset mid-SEND aborts the message; no partial-order count; after release the next qualifying packet starts a fresh message at byte 0.

Structure
REQ-027 Package order_gen_pkg holds the state enum, HDR_BYTE=8'hA5, MSG_LEN=10.
REQ-028 One sub-module, sat_cnt16 (16-bit saturating incrementer with enable), instantiated for order_count and drop_count.

Verification
REQ-029 price=900, qty=200, tx_ready=1 -> 10 consecutive bytes A5 00 00 03 84 00 00 00 C8 4F, order_count=1.
REQ-030 price=1001, qty=10 -> no tx_valid, both counters 0; price=1000 -> order sent.
REQ-031 qty=800 -> qty bytes 00 00 01 F4 (clipped to 500); qty=0 -> ignored.
REQ-032 tx_ready low 5 cycles at byte 3 -> tx_data=0x03 and tx_valid held all 5 cycles, then sequence resumes intact.
REQ-033 Second qualifying packet during SEND and one during last COOL cycle -> drop_count=2, one message only; packet on first IDLE cycle -> sent.
REQ-034 rst_n asserted at byte 5 -> outputs zero immediately; after release new packet yields full message from 0xA5, order_count=1.
